// File: rtl/commit_trace_sink.sv
// commit_trace_sink: captures retired-instruction records from the writeback debug
// commit bus into a first-word-fall-through FIFO and drains them over a valid/ready
// stream. The pipeline is never stalled; commits that arrive while the FIFO is full
// are dropped and counted with a saturating counter and a sticky overflow flag.
// Optional feature macro: COMMIT_TRACE_STAMP_EN adds a 32-bit cycle stamp per record.
module commit_trace_sink #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dbg_commit,
  input  logic [63:0]            dbg_pc,
  input  logic [4:0]             dbg_reg_num,
  input  logic [63:0]            dbg_wdata,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_pc,
  output logic [4:0]             out_reg_num,
  output logic [63:0]            out_wdata,
  output logic [31:0]            out_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic empty, full, pop, push, drop;

  // Record storage; deliberately not reset so it can map onto plain RAM.
  logic [63:0] pc_mem [DEPTH];
  logic [4:0]  rn_mem [DEPTH];
  logic [63:0] wd_mem [DEPTH];

  // Handshake decode: a full FIFO popped this cycle still accepts the new commit.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    pop   = !empty && out_ready;
    push  = dbg_commit && (!full || pop);
    drop  = dbg_commit && full && !pop;
  end

  // Next-state for pointers and drop bookkeeping; clear takes priority over a drop.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control state register; reset discards every held record at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write the incoming record into the slot addressed by the write pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wptr_q[AW-1:0]] <= dbg_pc;
      rn_mem[wptr_q[AW-1:0]] <= dbg_reg_num;
      wd_mem[wptr_q[AW-1:0]] <= dbg_wdata;
    end
  end

`ifdef COMMIT_TRACE_STAMP_EN
  logic [31:0] stamp_q;
  logic [31:0] st_mem [DEPTH];

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_q + 32'd1;
  end

  // Capture the cycle stamp alongside each pushed record.
  always_ff @(posedge clock) begin
    if (push) st_mem[wptr_q[AW-1:0]] <= stamp_q;
  end

  // Head stamp falls through with the rest of the record.
  always_comb out_stamp = st_mem[rptr_q[AW-1:0]];
`else
  // Without stamping the field is a constant zero.
  always_comb out_stamp = 32'h0;
`endif

  // First-word-fall-through outputs read straight from storage at the read pointer.
  always_comb begin
    out_valid   = !empty;
    out_pc      = pc_mem[rptr_q[AW-1:0]];
    out_reg_num = rn_mem[rptr_q[AW-1:0]];
    out_wdata   = wd_mem[rptr_q[AW-1:0]];
    level       = wptr_q - rptr_q;
    overflow    = overflow_q;
    drop_cnt    = drop_cnt_q;
  end

endmodule

// File: tb/tb_commit_trace_sink.sv
// Self-checking bench for commit_trace_sink: a queue model of the trace FIFO is
// compared against the DUT on every falling edge, with directed literal checks on top.
module tb_commit_trace_sink;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dbg_commit = 1'b0;
  logic [63:0] dbg_pc = '0;
  logic [4:0]  dbg_reg_num = '0;
  logic [63:0] dbg_wdata = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_reg_num;
  logic [63:0] out_wdata;
  logic [31:0] out_stamp;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int passed = 0;

  commit_trace_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .dbg_commit(dbg_commit), .dbg_pc(dbg_pc),
    .dbg_reg_num(dbg_reg_num), .dbg_wdata(dbg_wdata), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_reg_num(out_reg_num), .out_wdata(out_wdata), .out_stamp(out_stamp),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rn;
    logic [63:0] wd;
    logic [31:0] st;
  } rec_t;

  // Model state
  rec_t        mq[$];
  logic        m_ovf;
  int unsigned m_drops;
  logic [31:0] m_cycle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Queue model: pop happens before push, a full queue only drops when nothing leaves.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_cycle = 32'd0;
    end else begin
      int n;
      bit did_pop;
      rec_t r;
      n = mq.size();
      did_pop = (n > 0) && out_ready;
      if (did_pop) void'(mq.pop_front());
      if (dbg_commit) begin
        if (n < DEPTH || did_pop) begin
          r.pc = dbg_pc; r.rn = dbg_reg_num; r.wd = dbg_wdata; r.st = m_cycle;
          mq.push_back(r);
        end else if (!clear) begin
          m_ovf = 1'b1;
          if (m_drops < (2**CNT_W - 1)) m_drops++;
        end
      end
      if (clear) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      m_cycle = m_cycle + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      check("valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      check("level", 64'(level), 64'(mq.size()));
      check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (mq.size() != 0) begin
        check("pc", out_pc, mq[0].pc);
        check("reg_num", 64'(out_reg_num), 64'(mq[0].rn));
        check("wdata", out_wdata, mq[0].wd);
`ifdef COMMIT_TRACE_STAMP_EN
        check("stamp", 64'(out_stamp), 64'(mq[0].st));
`else
        check("stamp", 64'(out_stamp), 64'd0);
`endif
      end
    end
  end

  // One clock: apply inputs, return on the following falling edge.
  task automatic drive(input logic c, input logic [63:0] pc, input logic [4:0] rn,
                       input logic [63:0] wd, input logic rdy, input logic clr);
    dbg_commit = c; dbg_pc = pc; dbg_reg_num = rn; dbg_wdata = wd;
    out_ready = rdy; clear = clr;
    @(negedge clock);
    $display("cyc commit=%0b pc=%h rn=%0d rdy=%0b clr=%0b -> valid=%0b level=%0d drop=%0d",
             c, pc, rn, rdy, clr, out_valid, level, drop_cnt);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 64'd0, 5'd0, 64'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    do_reset();

    // 1: single commit, consumer ready
    drive(1'b1, 64'h8000_0000, 5'd5, 64'h1234, 1'b1, 1'b0);
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_pc", out_pc, 64'h8000_0000);
    check("t1_rn", 64'(out_reg_num), 64'd5);
    check("t1_wd", out_wdata, 64'h1234);
    idle(1'b1);
    check("t1_level", 64'(level), 64'd0);

    // 2: DEPTH+3 commits with consumer stalled
    for (int i = 0; i < DEPTH + 3; i++)
      drive(1'b1, 64'h2000 + 64'(i * 4), 5'(i), 64'(i * 7), 1'b0, 1'b0);
    check("t2_level", 64'(level), 64'd16);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd3);
    check("t2_overflow", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_pc", out_pc, 64'h2000 + 64'(i * 4));
      idle(1'b1);
    end
    check("t2_empty", {63'd0, out_valid}, 64'd0);

    // 3: full FIFO popped and pushed in the same cycle
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 64'h3000 + 64'(i * 4), 5'd1, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 64'hAAAA, 5'd31, 64'hBEEF, 1'b1, 1'b0);
    check("t3_level", 64'(level), 64'd16);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd3);
    check("t3_head", out_pc, 64'h3004);
    for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
    check("t3_last_pc", out_pc, 64'hAAAA);
    check("t3_last_rn", 64'(out_reg_num), 64'd31);
    idle(1'b1);

    // 4: clear coincident with a drop
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 64'h4000 + 64'(i), 5'd2, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 64'h4FFF, 5'd2, 64'd0, 1'b0, 1'b1);
    check("t4_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t4_overflow", {63'd0, overflow}, 64'd0);
    drive(1'b1, 64'h4FFE, 5'd2, 64'd0, 1'b0, 1'b0);
    check("t4_redrop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // 5: reset mid-drain with 5 entries held
    for (int i = 0; i < 7; i++)
      drive(1'b1, 64'h5000 + 64'(i), 5'd3, 64'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t5_level", 64'(level), 64'd5);
    do_reset();
    drive(1'b1, 64'h6000, 5'd4, 64'h11, 1'b0, 1'b0);
    drive(1'b1, 64'h6008, 5'd6, 64'h22, 1'b0, 1'b0);
    check("t5_post_level", 64'(level), 64'd2);
    check("t5_post_pc0", out_pc, 64'h6000);
    idle(1'b1);
    check("t5_post_pc1", out_pc, 64'h6008);
    idle(1'b1);

    // 6: stamps of commits at cycles 10 and 13 after reset
    do_reset();
    for (int i = 0; i < 10; i++) idle(1'b0);
    drive(1'b1, 64'h7000, 5'd7, 64'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 64'h7004, 5'd8, 64'd0, 1'b0, 1'b0);
`ifdef COMMIT_TRACE_STAMP_EN
    check("t6_stamp0", 64'(out_stamp), 64'd10);
`else
    check("t6_stamp0", 64'(out_stamp), 64'd0);
`endif
    idle(1'b1);
`ifdef COMMIT_TRACE_STAMP_EN
    check("t6_stamp1", 64'(out_stamp), 64'd13);
`else
    check("t6_stamp1", 64'(out_stamp), 64'd0);
`endif
    check("t6_pc1", out_pc, 64'h7004);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
